// File: rtl/wi23_defs.sv
// Shared instruction-memory geometry and the fetch-queue entry format
// used by the instruction fetch unit.
package wi23_defs;

    localparam int IMEM_DEPTH = 8;
    localparam int IMEM_WIDTH = 16;

    typedef struct packed {
        logic [IMEM_DEPTH-1:0] pc;
        logic [IMEM_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_q.sv
// Generic synchronous FIFO with a registered head, flush and async active-low reset.
// The head register holds its last value when the queue runs empty.
module ifetch_q #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_after_pop;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             do_pop, do_push;

    assign valid   = (count_reg != '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign dout    = dout_reg;
    assign do_pop  = pop && valid && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // Next head comes from storage unless the entry being pushed becomes the head.
    always_comb begin
        rd_ptr_next     = rd_ptr_reg + PTR_W'(do_pop);
        count_after_pop = count_reg - CNT_W'(do_pop);
        dout_next       = dout_reg;
        if (count_after_pop != '0) begin
            dout_next = mem[rd_ptr_next];
        end else if (do_push) begin
            dout_next = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            dout_reg   <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(do_push);
            count_reg  <= count_after_pop + CNT_W'(do_push);
            dout_reg   <= dout_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC register, fetch/redirect control and a small instruction queue.
// Optional fetch-event counter enabled by defining IFETCH_PERF_EN.
module ifetch
    import wi23_defs::*;
#(
    parameter logic [IMEM_DEPTH-1:0] RESET_PC = '0,
    parameter int                    QDEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [IMEM_DEPTH-1:0] imem_addr_o,
    input  logic [IMEM_WIDTH-1:0] imem_inst_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [IMEM_DEPTH-1:0] redirect_pc_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [IMEM_WIDTH-1:0] inst_o,
    output logic [IMEM_DEPTH-1:0] pc_o
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]           fetch_cnt_o
`endif
);
    logic [IMEM_DEPTH-1:0] pc_reg;
    logic                  q_full;
    logic                  pop;
    logic                  fetch;
    fetch_entry_t          push_entry;
    fetch_entry_t          head_entry;

    assign imem_addr_o = pc_reg;
    assign pop         = inst_valid_o && inst_ready_i;
    assign fetch       = !stall_i && !redirect_i && (!q_full || pop);
    assign push_entry  = '{pc: pc_reg, inst: imem_inst_i};
    assign inst_o      = head_entry.inst;
    assign pc_o        = head_entry.pc;

    // Redirect wins over everything: the fetch for this cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else if (redirect_i) begin
            pc_reg <= redirect_pc_i;
        end else if (fetch) begin
            pc_reg <= pc_reg + IMEM_DEPTH'(1);
        end
    end

    ifetch_q #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_q (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_i),
        .push  (fetch),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head_entry),
        .valid (inst_valid_o),
        .full  (q_full)
    );

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_reg <= '0;
        end else if (fetch && (fetch_cnt_reg != 32'hFFFF_FFFF)) begin
            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_reg;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_ifetch;
    import wi23_defs::*;

    localparam int QD = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  stall = 1'b0;
    logic                  redirect = 1'b0;
    logic                  ready = 1'b0;
    logic [IMEM_DEPTH-1:0] redirect_pc = '0;
    logic [IMEM_DEPTH-1:0] imem_addr;
    logic [IMEM_DEPTH-1:0] pc_o;
    logic [IMEM_WIDTH-1:0] imem_inst;
    logic [IMEM_WIDTH-1:0] inst_o;
    logic                  inst_valid;
`ifdef IFETCH_PERF_EN
    logic [31:0]           fetch_cnt;
`endif

    logic [IMEM_WIDTH-1:0] img [1 << IMEM_DEPTH];

    int checks = 0;
    int errors = 0;

    // reference model state
    fetch_entry_t          mq[$];
    fetch_entry_t          m_head;
    logic [IMEM_DEPTH-1:0] m_pc;
    longint                m_fetches;

    assign imem_inst = img[imem_addr];

    always #5 clk = ~clk;

    ifetch #(.RESET_PC('0), .QDEPTH(QD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr_o   (imem_addr),
        .imem_inst_i   (imem_inst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .inst_valid_o  (inst_valid),
        .inst_ready_i  (ready),
        .inst_o        (inst_o),
        .pc_o          (pc_o)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_cnt_o   (fetch_cnt)
`endif
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        mq.delete();
        m_pc      = '0;
        m_head    = '0;
        m_fetches = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the posedge, return at the negedge.
    task automatic cycle(input logic s, input logic r, input logic [IMEM_DEPTH-1:0] rpc,
                         input logic rdy);
        bit do_pop, do_fetch;
        stall = s; redirect = r; redirect_pc = rpc; ready = rdy;
        @(posedge clk);
        do_pop = (mq.size() > 0) && rdy;
        if (r) begin
            mq.delete();
            m_pc = rpc;
        end else begin
            do_fetch = !s && ((mq.size() < QD) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_fetch) begin
                mq.push_back('{pc: m_pc, inst: img[m_pc]});
                m_pc = m_pc + 1'b1;
                m_fetches++;
            end
        end
        if (mq.size() > 0) m_head = mq[0];
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; ready = 1'b0; redirect_pc = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", inst_valid);
        end
        checks++;
        if (imem_addr !== '0) begin
            errors++; $display("FAIL reset_addr got %0h want 0", imem_addr);
        end
        checks++;
        if (pc_o !== '0) begin
            errors++; $display("FAIL reset_pc_o got %0h want 0", pc_o);
        end
        checks++;
        if (inst_o !== '0) begin
            errors++; $display("FAIL reset_inst_o got %0h want 0", inst_o);
        end
`ifdef IFETCH_PERF_EN
        checks++;
        if (fetch_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got %0d want 0", fetch_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: valid=%b addr=%0h", inst_valid, imem_addr);
    endtask

    task automatic test_stream();
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (inst_valid !== 1'b1 || pc_o !== IMEM_DEPTH'(k)) begin
                errors++; $display("FAIL stream_pc got v=%b pc=%0h want v=1 pc=%0h", inst_valid, pc_o, k);
            end
            checks++;
            if (inst_o !== img[k]) begin
                errors++; $display("FAIL stream_inst got %0h want %0h", inst_o, img[k]);
            end
            $display("stream: pc_o=%0h inst_o=%0h", pc_o, inst_o);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, '0, 1'b0);
            checks++;
            if (inst_valid !== 1'b1 || pc_o !== '0) begin
                errors++; $display("FAIL bp_hold got v=%b pc=%0h want v=1 pc=0", inst_valid, pc_o);
            end
        end
        checks++;
        if (imem_addr !== 8'd2) begin
            errors++; $display("FAIL bp_addr got %0h want 2", imem_addr);
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (pc_o !== 8'd1 || inst_o !== img[1]) begin
            errors++; $display("FAIL bp_resume1 got pc=%0h want 1", pc_o);
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (pc_o !== 8'd2 || inst_o !== img[2]) begin
            errors++; $display("FAIL bp_resume2 got pc=%0h want 2", pc_o);
        end
        $display("backpressure: pc_o=%0h addr=%0h", pc_o, imem_addr);
    endtask

    task automatic test_redirect_full();
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 8'h40, 1'b1);
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL redir_flush got v=%b want 0", inst_valid);
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (inst_valid !== 1'b1 || pc_o !== 8'h40 || inst_o !== img[8'h40]) begin
            errors++; $display("FAIL redir_first got v=%b pc=%0h want v=1 pc=40", inst_valid, pc_o);
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (pc_o !== 8'h41) begin
            errors++; $display("FAIL redir_second got pc=%0h want 41", pc_o);
        end
        $display("redirect_full: pc_o=%0h", pc_o);
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, 1'b1, 8'h10, 1'b1);
        cycle(1'b0, 1'b1, 8'h20, 1'b1);
        checks++;
        if (inst_valid !== 1'b0 || imem_addr !== 8'h20) begin
            errors++; $display("FAIL b2b_flush got v=%b addr=%0h want v=0 addr=20", inst_valid, imem_addr);
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (inst_valid !== 1'b1 || pc_o !== 8'h20) begin
            errors++; $display("FAIL b2b_first got v=%b pc=%0h want v=1 pc=20", inst_valid, pc_o);
        end
        $display("back_to_back: pc_o=%0h", pc_o);
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 8'hFF, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (inst_valid !== 1'b1 || pc_o !== 8'hFF) begin
            errors++; $display("FAIL wrap_ff got v=%b pc=%0h want v=1 pc=ff", inst_valid, pc_o);
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (pc_o !== 8'h00 || inst_o !== img[0] || imem_addr !== 8'h01) begin
            errors++; $display("FAIL wrap_zero got pc=%0h addr=%0h want pc=0 addr=1", pc_o, imem_addr);
        end
        $display("wrap: pc_o=%0h addr=%0h", pc_o, imem_addr);
    endtask

    task automatic test_stall_drain();
        logic [IMEM_DEPTH-1:0] held_addr;
        logic [IMEM_DEPTH-1:0] second_pc;
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0, 1'b0);
        held_addr = m_pc;
        second_pc = mq[1].pc;
        cycle(1'b1, 1'b0, '0, 1'b1);
        checks++;
        if (inst_valid !== 1'b1 || pc_o !== second_pc) begin
            errors++; $display("FAIL stall_pop1 got v=%b pc=%0h want v=1 pc=%0h", inst_valid, pc_o, second_pc);
        end
        cycle(1'b1, 1'b0, '0, 1'b1);
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL stall_empty got v=%b want 0", inst_valid);
        end
        cycle(1'b1, 1'b0, '0, 1'b1);
        checks++;
        if (inst_valid !== 1'b0 || imem_addr !== held_addr) begin
            errors++; $display("FAIL stall_addr got v=%b addr=%0h want v=0 addr=%0h", inst_valid, imem_addr, held_addr);
        end
        $display("stall_drain: valid=%b addr=%0h", inst_valid, imem_addr);
    endtask

    task automatic test_random();
        logic s, r, rdy;
        logic [IMEM_DEPTH-1:0] rpc;
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                checks++;
                if (inst_valid !== 1'b0 || imem_addr !== '0 || pc_o !== '0 || inst_o !== '0) begin
                    errors++; $display("FAIL rand_async_reset got v=%b addr=%0h pc=%0h inst=%0h want 0", inst_valid, imem_addr, pc_o, inst_o);
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
            s   = ($urandom_range(3) == 0);
            r   = ($urandom_range(15) == 0);
            rdy = ($urandom_range(3) != 0);
            rpc = IMEM_DEPTH'($urandom);
            cycle(s, r, rpc, rdy);
            checks++;
            if (inst_valid !== (mq.size() != 0)) begin
                errors++; $display("FAIL rand_valid n=%0d got %b want %b", n, inst_valid, mq.size() != 0);
            end
            checks++;
            if (pc_o !== m_head.pc || inst_o !== m_head.inst) begin
                errors++; $display("FAIL rand_head n=%0d got pc=%0h inst=%0h want pc=%0h inst=%0h", n, pc_o, inst_o, m_head.pc, m_head.inst);
            end
            checks++;
            if (imem_addr !== m_pc) begin
                errors++; $display("FAIL rand_addr n=%0d got %0h want %0h", n, imem_addr, m_pc);
            end
`ifdef IFETCH_PERF_EN
            checks++;
            if (fetch_cnt !== 32'(m_fetches)) begin
                errors++; $display("FAIL rand_cnt n=%0d got %0d want %0d", n, fetch_cnt, m_fetches);
            end
`endif
            $display("rand n=%0d s=%b r=%b rdy=%b v=%b pc_o=%0h addr=%0h", n, s, r, rdy, inst_valid, pc_o, imem_addr);
        end
    endtask

`ifdef IFETCH_PERF_EN
    task automatic test_perf();
        apply_reset();
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, 8'h33, 1'b1);
        checks++;
        if (fetch_cnt !== 32'd10) begin
            errors++; $display("FAIL perf_count got %0d want 10", fetch_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fetch_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_reset got %0d want 0", fetch_cnt);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        $display("perf: fetch_cnt=%0d", fetch_cnt);
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << IMEM_DEPTH); i++) img[i] = IMEM_WIDTH'($urandom);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_back_to_back();
        test_wrap();
        test_stall_drain();
        test_random();
`ifdef IFETCH_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL import wi23_defs and size all address/instruction fields from IMEM_DEPTH / IMEM_WIDTH.
REQ-002 Parameter: RESET_PC, 0, word address loaded into PC on reset.
REQ-003 Parameter: QDEPTH, 2, instruction queue entries; power of two, >= 2.
REQ-004 Port: clk  in  1  single clock; all state updates on posedge.
REQ-005 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-006 Port: imem_addr_o  out  IMEM_DEPTH  word address to instruction memory; equals current PC.
REQ-007 Port: imem_inst_i  in  IMEM_WIDTH  instruction word for imem_addr_o, valid before next posedge.
REQ-008 Port: stall_i  in  1  level; blocks new fetches, queue still drains.
REQ-009 Port: redirect_i  in  1  one-cycle pulse; flush and load new PC.
REQ-010 Port: redirect_pc_i  in  IMEM_DEPTH  target word address for redirect.
REQ-011 Port: inst_valid_o  out  1  queue head valid.
REQ-012 Port: inst_ready_i  in  1  downstream accepts head this cycle.
REQ-013 Port: inst_o  out  IMEM_WIDTH  queue head instruction.
REQ-014 Port: pc_o  out  IMEM_DEPTH  word address of queue head.

Function
REQ-015 SHALL hold PC register; imem_addr_o = PC, combinational from register only.
REQ-016 pop = inst_valid_o && inst_ready_i; fetch = !stall_i && !redirect_i && (count < QDEPTH || pop).
REQ-017 On fetch: push {PC, imem_inst_i} at tail, PC <= PC + 1 modulo 2^IMEM_DEPTH (all-ones wraps to 0).
REQ-018 On pop: head advances; simultaneous push and pop keeps count unchanged, legal when full.
REQ-019 Queue empty: inst_valid_o = 0; inst_o and pc_o hold last head value, don't-care for consumers.
REQ-020 Redirect has priority over fetch, pop and stall: count <= 0, PC <= redirect_pc_i, imem_inst_i that cycle discarded.
REQ-021 First post-redirect instruction appears on inst_valid_o one cycle after redirect, provided stall_i = 0.
REQ-022 Back-to-back redirects: last one wins; no instruction pushed between them.
REQ-023 Queue outputs registered (head of FIFO storage); no combinational path inst_ready_i -> inst_valid_o.
REQ-024 Steady state, ready held 1, stall 0: one instruction per cycle, consecutive pc_o values.
REQ-025 Head (inst_o, pc_o) SHALL remain stable while inst_valid_o = 1 and inst_ready_i = 0.

Reset
REQ-026 rst_n low asynchronously: PC = RESET_PC, count = 0, read/write pointers = 0, inst_valid_o = 0.
REQ-027 inst_o and pc_o reset to 0; perf counter (if present) resets to 0.
REQ-028 Reset mid-operation discards queue contents; first fetch from RESET_PC on first posedge after rst_n rises.

Configuration
REQ-029 Macro IFETCH_PERF_EN defined: adds port fetch_cnt_o out 32, counting fetch events, saturating at 32'hFFFF_FFFF, not cleared by redirect.
REQ-030 Macro IFETCH_PERF_EN undefined: port and counter absent; all other behaviour identical.

Structure
REQ-031 IMEM_DEPTH, IMEM_WIDTH and a fetch-entry struct typedef (pc, inst) SHALL live in wi23_defs.
REQ-032 Queue SHALL be sub-module ifetch_q (generic sync FIFO, async active-low reset, flush input); PC and control in ifetch.

Verification
REQ-033 Reset release, ready = 1, stall = 0: pc_o sequence 0,1,2,3 on consecutive cycles from cycle 1; inst_o matches memory image.
REQ-034 Ready = 0 for 5 cycles: queue fills to 2 (pc_o 0, held), imem_addr_o holds 2; ready = 1 resumes with pc_o 1 then 2.
REQ-035 Redirect to 0x40 while full: next cycle inst_valid_o = 0, following cycle pc_o = 0x40; no pre-redirect entry emitted.
REQ-036 PC = all-ones, fetch: next pc_o sequence all-ones then 0.
REQ-037 Stall held 3 cycles with queue holding 2: two pops drain, inst_valid_o = 0, imem_addr_o unchanged.
REQ-038 IFETCH_PERF_EN: 10 fetches plus one redirect -> fetch_cnt_o = 10; mid-run rst_n low -> 0 immediately.
